// File: rtl/frame_detector.sv
// Purpose: byte-stream frame parser (sync A5/5A, length, payload, XOR checksum).
// Latency: one clock from accepted byte to any output; all outputs registered.
// Backpressure: none; en qualifies input bytes, en=0 holds all state, pulses read 0.
//
// Ports:
//   clock, reset (async, active low)
//   din[7:0], en        : input byte and its valid qualifier
//   payload[7:0]        : registered payload byte, qualified by payload_valid
//   frame_start/done/err: one-cycle event pulses
//   busy                : high while in LEN, DATA or CHK
module frame_detector #(
  parameter logic [7:0]  SYNC0  = 8'hA5,
  parameter logic [7:0]  SYNC1  = 8'h5A,
  parameter int unsigned MAXLEN = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       en,
  output logic [7:0] payload,
  output logic       payload_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    GOT0 = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] payload_q, payload_d;
  logic       pv_q, pv_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    payload_d = payload_q;
    pv_d      = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (din == SYNC0) state_d = GOT0;
        end
        GOT0: begin
          if (din == SYNC1)      state_d = LEN;
          else if (din == SYNC0) state_d = GOT0;  // repeated sync start
          else                   state_d = HUNT;
        end
        LEN: begin
          if (din == 8'd0) begin
            // Empty frame: go straight to the checksum byte, expecting 00.
            start_d = 1'b1;
            csum_d  = 8'd0;
            state_d = CHK;
          end else if (din <= MAXLEN_B) begin
            start_d = 1'b1;
            csum_d  = 8'd0;
            cnt_d   = din;
            state_d = DATA;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
        DATA: begin
          // Sync bytes here are ordinary payload; no resync inside a frame.
          payload_d = din;
          pv_d      = 1'b1;
          csum_d    = csum_q ^ din;
          cnt_d     = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = CHK;
        end
        CHK: begin
          if (din == csum_q) done_d = 1'b1;
          else               err_d  = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end

    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      cnt_q     <= 8'd0;
      csum_q    <= 8'd0;
      payload_q <= 8'd0;
      pv_q      <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      payload_q <= payload_d;
      pv_q      <= pv_d;
      start_q   <= start_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign payload       = payload_q;
  assign payload_valid = pv_q;
  assign frame_start   = start_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign busy          = busy_q;

endmodule

// File: doc/frame_detector.md
# frame_detector

Byte-stream frame parser that sits directly downstream of the 8-bit delay-line shift register and consumes its output byte. It hunts for a two-byte sync word, reads a length byte, forwards the payload bytes with a valid strobe, and checks a trailing XOR checksum. It reports start, done and error events to the control logic.

## Interface
Parameters:
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.
- MAXLEN, 16: largest legal payload length, range 1..255.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- din  input  8  byte from the upstream shift register output.
- en  input  1  byte-valid qualifier. din is consumed only on edges where en=1.
- payload  output  8  registered payload byte.
- payload_valid  output  1  one-cycle pulse when payload holds a new byte.
- frame_start  output  1  one-cycle pulse when a legal length byte is accepted.
- frame_done  output  1  one-cycle pulse when the checksum matches.
- frame_err  output  1  one-cycle pulse on a length or checksum error.
- busy  output  1  high in the LEN, DATA and CHK states.

## Operation
- Reset values:
  - State is HUNT.
  - Length counter and running checksum are 0.
  - payload is 8'h00.
  - All pulse outputs and busy are 0.
- Cycles with en=0 hold all state. All pulse outputs read 0 in those cycles.
- State transitions, evaluated only on edges with en=1:
  - HUNT: din==SYNC0 -> GOT0. Otherwise stay in HUNT.
  - GOT0: din==SYNC1 -> LEN. din==SYNC0 -> stay in GOT0 (repeated sync start). Any other byte -> HUNT.
  - LEN, din==0: pulse frame_start, clear checksum, go to CHK. An empty frame is legal.
  - LEN, 1<=din<=MAXLEN: load the counter with din, clear the checksum, pulse frame_start, go to DATA.
  - LEN, din>MAXLEN: pulse frame_err, go to HUNT.
  - DATA, per byte: register din into payload, pulse payload_valid, XOR din into the checksum, decrement the counter. On the byte that takes the counter to 0, go to CHK.
  - CHK: din==checksum -> pulse frame_done. Otherwise pulse frame_err. Either way go to HUNT.
- Sync bytes appearing inside DATA are payload. They are not re-synchronised.
- The checksum covers payload bytes only. It excludes the sync and length bytes. An empty frame expects a checksum byte of 8'h00.
- Counter width is 8 bits unsigned. The length comparison is unsigned.
- Only one pulse output fires per accepted byte.
- Asserting reset mid-frame immediately clears every output and returns the block to HUNT. No frame_err is reported.

## Timing
- All outputs are registered.
- An event caused by the byte accepted at edge N is visible in the cycle after edge N, and lasts exactly one cycle.
- payload latency: one clock from din to payload.
- busy rises the cycle after the SYNC1 byte is accepted. It falls the cycle after the checksum byte is accepted.
- Back-to-back frames: the first SYNC0 of the next frame may be presented on the cycle immediately after the checksum byte.
- en may be 1 every cycle. Full throughput is one byte per clock.
- Minimum frame is 4 accepted bytes: SYNC0, SYNC1, length, checksum.

## Test plan
- Good frame: stream A5 5A 03 11 22 44 77 with en=1 throughout.
  - frame_start pulses once.
  - payload_valid pulses 3 times, with payload 11, 22, 44.
  - frame_done pulses the cycle after 77.
  - busy is high for 5 cycles.
- Bad checksum: stream A5 5A 02 0F F0 00.
  - payload_valid pulses twice.
  - frame_err pulses after 00 (expected checksum is FF).
  - frame_done never pulses.
- Length errors:
  - Stream A5 5A 11 with MAXLEN=16: frame_err pulses, no frame_start, state returns to HUNT.
  - Stream A5 5A 00 00: frame_start pulses, then frame_done, with no payload_valid.
- Resync and gaps:
  - Stream 00 A5 A5 5A 01 3C 3C with en toggled 1/0 on alternate cycles.
  - frame_done pulses exactly once.
  - No output changes in en=0 cycles.
- Reset mid-frame:
  - Assert reset after A5 5A 04 11.
  - All outputs read 0 while reset is low.
  - After release, stream A5 5A 01 99 99: a single clean frame_done, with no stale payload_valid.
